sd_init_seq: RTL
================

Name: sd_init_seq

Overview:
- Card-initialisation sequencer directly upstream of the CMD line driver.
- After a start request it issues the SD identification/setup command chain through the driver's start/index/argument interface and interprets each 32-bit response.
- Outputs card-ready status, RCA and capacity class; on completion the data-path controller takes over the driver.
- Any failure is reported with an error code.

Parameters:
- RESP_TIMEOUT, 16'd2048: clocks allowed in WAIT_DONE before the command is aborted.
- ACK_TIMEOUT, 4'd8: clocks allowed for the driver to drop done after ostart rises.
- ACMD41_TRIES, 16'd1000: maximum CMD55+ACMD41 pairs before giving up.

Ports:
- iclk  in  1  SD clock, shared with CMD driver
- irst  in  1  reset
- istart  in  1  begin initialisation, rising-edge detected
- ocmd_start  out  1  to driver start input
- ocmd_index  out  6  to driver command index
- ocmd_arg  out  32  to driver command argument
- ocmd_rst  out  1  one-cycle abort pulse, ORed into driver reset
- iresp  in  32  driver response (argument field of R1/R3/R6/R7)
- idone  in  1  driver done/idle flag
- ordy  out  1  card initialised, 4-bit bus selected
- oerr  out  1  initialisation failed
- oerr_code  out  3  1=ack timeout, 2=response timeout, 3=CMD8 echo mismatch, 4=ACMD41 tries exhausted
- orca  out  16  relative card address
- ohcs  out  1  card capacity status from final ACMD41

Behaviour:
- Reset: one clock, synchronous, active-high (irst). Reset has priority over all other inputs.
  - FSM goes to IDLE.
  - All outputs are 0 (ocmd_index 0, ocmd_arg 0, orca 0, ohcs 0, oerr_code 0).
  - Step register, tries counter and timer are cleared.
- Command step list, held in step register:
  - S0: CMD0, arg 0
  - S1: CMD8, arg 0x000001AA
  - S2: CMD55, arg 0
  - S3: CMD41, arg 0x40FF8000
  - S4: CMD2, arg 0
  - S5: CMD3, arg 0
  - S6: CMD7, arg {orca,16'h0}
  - S7: CMD55, arg {orca,16'h0}
  - S8: CMD6, arg 0x00000002
- ocmd_index/ocmd_arg are registered and stable from the cycle ocmd_start rises until idone returns high.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CHECK, ABORT, READY, ERROR.
- IDLE: on rising edge of istart, step=S0, tries=0, clear ordy/oerr/oerr_code, go to ISSUE.
- ISSUE: load index/arg for the current step, set ocmd_start=1, clear timer, go to WAIT_ACK.
- WAIT_ACK: ocmd_start held 1.
  - idone==0: ocmd_start=0, timer cleared, go to WAIT_DONE.
  - Timer reaches ACK_TIMEOUT: ERROR, code 1.
- WAIT_DONE:
  - idone==1: go to CHECK.
  - Timer reaches RESP_TIMEOUT: go to ABORT.
  - The driver's internal CRC retries keep idone low; persistent CRC failure therefore ends in a timeout.
- ABORT: ocmd_rst=1 for exactly one cycle.
  - Step S0: CMD0 has no response, so this is the normal exit; step=S1, go to ISSUE.
  - Any other step: ERROR, code 2.
- CHECK: iresp is sampled in this cycle only.
  - S1: iresp[11:0]!=12'h1AA → ERROR, code 3; else step S2.
  - S3, iresp[31]==1: ohcs=iresp[30], go to S4.
  - S3, iresp[31]==0: tries+1.
    - tries==ACMD41_TRIES-1 → ERROR, code 4.
    - Otherwise back to S2.
  - S5: orca=iresp[31:16].
  - S8: go to READY.
  - Other steps: step+1, go to ISSUE.
- READY: ordy=1. ERROR: oerr=1, code held.
  - Both hold until irst or a new istart rising edge, which restarts from S0.
- istart edges are ignored outside IDLE/READY/ERROR.
- Timer is 16-bit saturating and cleared on every state entry. tries counter is 16-bit.
- Latency from istart edge to first ocmd_start rise: 2 cycles.

Test Plan:
- Nominal: driver model with CMD0 silent and fixed responses (CMD8 0x000001AA; ACMD41 0x00FF8000 twice then 0xC0FF8000; CMD3 0xB3680500).
  - Required: command order 0,8,55,41,55,41,55,41,2,3,7,55,6.
  - One ocmd_rst pulse after CMD0.
  - ordy=1, orca=0xB368, ohcs=1, CMD7/CMD55 arg=0xB3680000.
- CMD8 returns 0x000001A5 → oerr=1, oerr_code=3, ocmd_start stays 0 afterwards.
- ACMD41 always busy with ACMD41_TRIES=3 → exactly 3 CMD41 issued, oerr_code=4.
- Driver never raises idone after CMD2 → ocmd_rst pulse at RESP_TIMEOUT, oerr_code=2.
- Driver ignores ocmd_start (idone stuck 1) → oerr_code=1 after ACK_TIMEOUT cycles.
- irst asserted mid-CMD41 WAIT_DONE → next cycle all outputs 0, IDLE. A new istart restarts from CMD0.

Source files
------------

// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer: walks the identification/setup command
// chain through the CMD line driver, checks each response and reports the
// card address, capacity class and ready/error status.
module sd_init_seq #(
  parameter logic [15:0] RESP_TIMEOUT = 16'd2048,
  parameter logic [3:0]  ACK_TIMEOUT  = 4'd8,
  parameter logic [15:0] ACMD41_TRIES = 16'd1000
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  output logic        ocmd_rst,
  input  logic [31:0] iresp,
  input  logic        idone,
  output logic        ordy,
  output logic        oerr,
  output logic [2:0]  oerr_code,
  output logic [15:0] orca,
  output logic        ohcs
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CHECK, ABORT, READY, ERROR
  } state_t;

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8
  } step_t;

  localparam logic [2:0] ERR_ACK   = 3'd1;
  localparam logic [2:0] ERR_RESP  = 3'd2;
  localparam logic [2:0] ERR_CMD8  = 3'd3;
  localparam logic [2:0] ERR_TRIES = 3'd4;

  // Timers are compared against the last allowed count so that a wait state
  // lasts exactly the configured number of clocks before giving up.
  localparam logic [15:0] ACK_LAST   = {12'd0, ACK_TIMEOUT} - 16'd1;
  localparam logic [15:0] RESP_LAST  = RESP_TIMEOUT - 16'd1;
  localparam logic [15:0] TRIES_LAST = ACMD41_TRIES - 16'd1;

  state_t      state;
  step_t       step;
  logic [15:0] timer;
  logic [15:0] timer_inc;
  logic [15:0] tries;
  logic        istart_q;
  logic        start_rise;
  logic [5:0]  step_index;
  logic [31:0] step_arg;
  logic        unused_resp;

  assign start_rise  = istart & ~istart_q;
  assign timer_inc   = (timer == '1) ? timer : timer + 16'd1;
  // Response bits 15:12 carry nothing this sequencer interprets.
  assign unused_resp = ^iresp[15:12];

  // Command table: index and argument for the current step.
  always_comb begin
    step_index = 6'd0;
    step_arg   = '0;
    case (step)
      S0: begin step_index = 6'd0;  step_arg = '0;             end
      S1: begin step_index = 6'd8;  step_arg = 32'h0000_01AA;  end
      S2: begin step_index = 6'd55; step_arg = '0;             end
      S3: begin step_index = 6'd41; step_arg = 32'h40FF_8000;  end
      S4: begin step_index = 6'd2;  step_arg = '0;             end
      S5: begin step_index = 6'd3;  step_arg = '0;             end
      S6: begin step_index = 6'd7;  step_arg = {orca, 16'h0};  end
      S7: begin step_index = 6'd55; step_arg = {orca, 16'h0};  end
      S8: begin step_index = 6'd6;  step_arg = 32'h0000_0002;  end
      default: begin step_index = 6'd0; step_arg = '0;         end
    endcase
  end

  // Sequencer FSM with registered driver-side and status outputs.
  always_ff @(posedge iclk) begin
    istart_q <= istart;
    if (irst) begin
      state      <= IDLE;
      step       <= S0;
      tries      <= '0;
      timer      <= '0;
      ocmd_start <= 1'b0;
      ocmd_index <= '0;
      ocmd_arg   <= '0;
      ocmd_rst   <= 1'b0;
      ordy       <= 1'b0;
      oerr       <= 1'b0;
      oerr_code  <= '0;
      orca       <= '0;
      ohcs       <= 1'b0;
    end else begin
      ocmd_rst <= 1'b0;
      case (state)
        IDLE, READY, ERROR: begin
          if (start_rise) begin
            step      <= S0;
            tries     <= '0;
            timer     <= '0;
            ordy      <= 1'b0;
            oerr      <= 1'b0;
            oerr_code <= '0;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          ocmd_index <= step_index;
          ocmd_arg   <= step_arg;
          ocmd_start <= 1'b1;
          timer      <= '0;
          state      <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (!idone) begin
            ocmd_start <= 1'b0;
            timer      <= '0;
            state      <= WAIT_DONE;
          end else if (timer >= ACK_LAST) begin
            ocmd_start <= 1'b0;
            oerr       <= 1'b1;
            oerr_code  <= ERR_ACK;
            timer      <= '0;
            state      <= ERROR;
          end else begin
            timer <= timer_inc;
          end
        end

        WAIT_DONE: begin
          if (idone) begin
            timer <= '0;
            state <= CHECK;
          end else if (timer >= RESP_LAST) begin
            ocmd_rst <= 1'b1;
            timer    <= '0;
            state    <= ABORT;
          end else begin
            timer <= timer_inc;
          end
        end

        ABORT: begin
          timer <= '0;
          // CMD0 never answers, so its timeout is the normal way forward.
          if (step == S0) begin
            step  <= S1;
            state <= ISSUE;
          end else begin
            oerr      <= 1'b1;
            oerr_code <= ERR_RESP;
            state     <= ERROR;
          end
        end

        CHECK: begin
          timer <= '0;
          state <= ISSUE;
          case (step)
            S1: begin
              if (iresp[11:0] != 12'h1AA) begin
                oerr      <= 1'b1;
                oerr_code <= ERR_CMD8;
                state     <= ERROR;
              end else begin
                step <= S2;
              end
            end
            S3: begin
              if (iresp[31]) begin
                ohcs <= iresp[30];
                step <= S4;
              end else if (tries == TRIES_LAST) begin
                oerr      <= 1'b1;
                oerr_code <= ERR_TRIES;
                state     <= ERROR;
              end else begin
                tries <= tries + 16'd1;
                step  <= S2;
              end
            end
            S5: begin
              orca <= iresp[31:16];
              step <= S6;
            end
            S8: begin
              ordy  <= 1'b1;
              state <= READY;
            end
            default: step <= step_t'(step + 4'd1);
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
